dsp_output_slew: RTL

//  Output conditioning stage downstream of the DSP router. It takes the two saturated 14-bit DAC sums and their overflow flags.
//  Per channel it applies a programmable slew-rate limit, a soft start/stop ramp and a hold (freeze) function, then drives the DAC.

---
 rtl/dsp_slew_pkg.sv | 28 ++
 rtl/dsp_slew_channel.sv | 142 ++++++++++++++
 rtl/dsp_output_slew.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/dsp_slew_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : dsp_slew_pkg                                                 |
// | Description : Shared state encodings, register offsets and defaults for    |
// |               the DSP output slew limiter.                                 |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
package dsp_slew_pkg;

  localparam int DW_DEF = 14;

  localparam logic [2:0] c_st_off   = 3'd0;
  localparam logic [2:0] c_st_slew  = 3'd1;
  localparam logic [2:0] c_st_track = 3'd2;
  localparam logic [2:0] c_st_hold  = 3'd3;
  localparam logic [2:0] c_st_rdown = 3'd4;

  localparam logic [15:0] c_addr_ctrl_a   = 16'h0010;
  localparam logic [15:0] c_addr_step_a   = 16'h0014;
  localparam logic [15:0] c_addr_presc    = 16'h0018;
  localparam logic [15:0] c_addr_status   = 16'h001C;
  localparam logic [15:0] c_addr_ctrl_b   = 16'h0020;
  localparam logic [15:0] c_addr_step_b   = 16'h0024;
  localparam logic [15:0] c_addr_satcnt_a = 16'h0028;
  localparam logic [15:0] c_addr_satcnt_b = 16'h002C;

endpackage
`default_nettype wire

// File: rtl/dsp_slew_channel.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : dsp_slew_channel                                             |
// | Description : One output channel: OFF/SLEW/TRACK/HOLD/RDOWN state machine, |
// |               step-clamped slew arithmetic and, when DSP_SLEW_SATCNT_EN is |
// |               defined, a saturating overflow event counter.                |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module dsp_slew_channel
  import dsp_slew_pkg::*;
#(
  parameter int DW       = DW_DEF,
  parameter int SATCNT_W = 32
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 tick,
  input  logic                 en,
  input  logic                 hold,
  input  logic [DW-2:0]        step,
  input  logic signed [DW-1:0] dat_i,
  input  logic                 ovf_i,
  input  logic                 satcnt_clr,
  output logic signed [DW-1:0] dat_o,
  output logic [2:0]           state_o,
  output logic [SATCNT_W-1:0]  satcnt_o
);

  logic [2:0]           r_state;
  logic [2:0]           w_state_nxt;
  logic signed [DW-1:0] r_out;
  logic signed [DW-1:0] w_out_nxt;
  logic signed [DW-1:0] w_target;
  logic signed [DW-1:0] w_out_upd;
  logic signed [DW:0]   w_diff;
  logic signed [DW:0]   w_step_ext;
  logic signed [DW:0]   w_delta;
  logic signed [DW:0]   w_sum;
  logic                 w_unused_sum_msb;

  always_comb begin
    case (r_state)
      c_st_slew, c_st_track: w_target = dat_i;
      c_st_hold:             w_target = r_out;
      default:               w_target = '0;
    endcase
  end

  assign w_diff     = {w_target[DW-1], w_target} - {r_out[DW-1], r_out};
  assign w_step_ext = {2'b00, step};

  // A zero step means no limit; otherwise clamp the move to +/-step.
  always_comb begin
    if (step == '0)
      w_delta = w_diff;
    else if (w_diff > w_step_ext)
      w_delta = w_step_ext;
    else if (w_diff < -w_step_ext)
      w_delta = -w_step_ext;
    else
      w_delta = w_diff;
  end

  // Moving toward an in-range target can never leave the DW range.
  assign w_sum            = {r_out[DW-1], r_out} + w_delta;
  assign w_out_upd        = w_sum[DW-1:0];
  assign w_unused_sum_msb = w_sum[DW];

  always_comb begin
    w_out_nxt = r_out;
    if (r_state == c_st_off)
      w_out_nxt = '0;
    else if (tick)
      w_out_nxt = w_out_upd;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_off: begin
        if (en) w_state_nxt = c_st_slew;
      end
      c_st_slew, c_st_track: begin
        if (!en)
          w_state_nxt = c_st_rdown;
        else if (hold)
          w_state_nxt = c_st_hold;
        else if (tick)
          w_state_nxt = (w_out_upd == dat_i) ? c_st_track : c_st_slew;
      end
      c_st_hold: begin
        if (!en)
          w_state_nxt = c_st_rdown;
        else if (!hold)
          w_state_nxt = c_st_slew;
      end
      c_st_rdown: begin
        if (en)
          w_state_nxt = c_st_slew;
        else if ((r_out == '0) || (tick && (w_out_upd == '0)))
          w_state_nxt = c_st_off;
      end
      default: w_state_nxt = c_st_off;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state <= c_st_off;
      r_out   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_out   <= w_out_nxt;
    end
  end

  assign dat_o   = r_out;
  assign state_o = r_state;

`ifdef DSP_SLEW_SATCNT_EN
  logic [SATCNT_W-1:0] r_satcnt;

  // Clear has priority so a write always leaves the counter at zero.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)
      r_satcnt <= '0;
    else if (satcnt_clr)
      r_satcnt <= '0;
    else if (ovf_i && !(&r_satcnt))
      r_satcnt <= r_satcnt + {{(SATCNT_W-1){1'b0}}, 1'b1};
  end

  assign satcnt_o = r_satcnt;
`else
  logic w_unused_sat;

  assign w_unused_sat = ovf_i ^ satcnt_clr;
  assign satcnt_o     = '0;
`endif

endmodule
`default_nettype wire

// File: rtl/dsp_output_slew.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : dsp_output_slew                                              |
// | Description : Two-channel DAC output conditioning (slew limit, soft ramp,  |
// |               hold) with shared tick prescaler and bus register file.      |
// |               Define DSP_SLEW_SATCNT_EN to build the saturation counters.  |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module dsp_output_slew
  import dsp_slew_pkg::*;
#(
  parameter int DW       = DW_DEF,
  parameter int PRESC_W  = 16,
  parameter int SATCNT_W = 32
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic signed [DW-1:0] dat_a_i,
  input  logic signed [DW-1:0] dat_b_i,
  input  logic                 ovf_a_i,
  input  logic                 ovf_b_i,
  output logic signed [DW-1:0] dat_a_o,
  output logic signed [DW-1:0] dat_b_o,
  input  logic [15:0]          addr,
  input  logic [31:0]          wdata,
  input  logic                 wen,
  input  logic                 ren,
  output logic                 ack,
  output logic [31:0]          rdata
);

  logic [1:0]          r_ctrl_a;
  logic [1:0]          r_ctrl_b;
  logic [DW-2:0]       r_step_a;
  logic [DW-2:0]       r_step_b;
  logic [PRESC_W-1:0]  r_presc;
  logic [PRESC_W-1:0]  r_presc_cnt;
  logic                r_ack;
  logic [31:0]         r_rdata;
  logic [31:0]         w_rdata_mux;
  logic                w_tick;
  logic                w_presc_wr;
  logic                w_clr_a;
  logic                w_clr_b;
  logic [2:0]          w_state_a;
  logic [2:0]          w_state_b;
  logic [SATCNT_W-1:0] w_satcnt_a;
  logic [SATCNT_W-1:0] w_satcnt_b;
  logic                w_unused_wdata;

  assign w_presc_wr     = wen && (addr == c_addr_presc);
  assign w_clr_a        = wen && (addr == c_addr_satcnt_a);
  assign w_clr_b        = wen && (addr == c_addr_satcnt_b);
  assign w_tick         = (r_presc_cnt == r_presc);
  assign w_unused_wdata = ^wdata;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)
      r_presc_cnt <= '0;
    else if (w_presc_wr || w_tick)
      r_presc_cnt <= '0;
    else
      r_presc_cnt <= r_presc_cnt + {{(PRESC_W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_ctrl_a <= '0;
      r_ctrl_b <= '0;
      r_step_a <= '0;
      r_step_b <= '0;
      r_presc  <= '0;
    end else if (wen) begin
      case (addr)
        c_addr_ctrl_a: r_ctrl_a <= wdata[1:0];
        c_addr_ctrl_b: r_ctrl_b <= wdata[1:0];
        c_addr_step_a: r_step_a <= wdata[DW-2:0];
        c_addr_step_b: r_step_b <= wdata[DW-2:0];
        c_addr_presc:  r_presc  <= wdata[PRESC_W-1:0];
        default: ;
      endcase
    end
  end

  always_comb begin
    w_rdata_mux = '0;
    case (addr)
      c_addr_ctrl_a:   w_rdata_mux = {30'd0, r_ctrl_a};
      c_addr_ctrl_b:   w_rdata_mux = {30'd0, r_ctrl_b};
      c_addr_step_a:   w_rdata_mux = 32'(r_step_a);
      c_addr_step_b:   w_rdata_mux = 32'(r_step_b);
      c_addr_presc:    w_rdata_mux = 32'(r_presc);
      c_addr_status:   w_rdata_mux = {25'd0, w_state_b, 1'b0, w_state_a};
      c_addr_satcnt_a: w_rdata_mux = 32'(w_satcnt_a);
      c_addr_satcnt_b: w_rdata_mux = 32'(w_satcnt_b);
      default:         w_rdata_mux = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_ack   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_ack   <= wen | ren;
      r_rdata <= ren ? w_rdata_mux : '0;
    end
  end

  assign ack   = r_ack;
  assign rdata = r_rdata;

  dsp_slew_channel #(
    .DW       (DW),
    .SATCNT_W (SATCNT_W)
  ) u_chan_a (
    .clk_i      (clk_i),
    .rstn_i     (rstn_i),
    .tick       (w_tick),
    .en         (r_ctrl_a[0]),
    .hold       (r_ctrl_a[1]),
    .step       (r_step_a),
    .dat_i      (dat_a_i),
    .ovf_i      (ovf_a_i),
    .satcnt_clr (w_clr_a),
    .dat_o      (dat_a_o),
    .state_o    (w_state_a),
    .satcnt_o   (w_satcnt_a)
  );

  dsp_slew_channel #(
    .DW       (DW),
    .SATCNT_W (SATCNT_W)
  ) u_chan_b (
    .clk_i      (clk_i),
    .rstn_i     (rstn_i),
    .tick       (w_tick),
    .en         (r_ctrl_b[0]),
    .hold       (r_ctrl_b[1]),
    .step       (r_step_b),
    .dat_i      (dat_b_i),
    .ovf_i      (ovf_b_i),
    .satcnt_clr (w_clr_b),
    .dat_o      (dat_b_o),
    .state_o    (w_state_b),
    .satcnt_o   (w_satcnt_b)
  );

endmodule
`default_nettype wire
